// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    MWAIT = 2'd2,
    ERR   = 2'd3
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/hz_forward_unit.sv
// E-stage operand forwarding select; the M-stage result has priority over W.
module hz_forward_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] i_ra_e,
  input  logic [3:0] i_wa3_m,
  input  logic [3:0] i_wa3_w,
  input  logic       i_reg_write_m,
  input  logic       i_reg_write_w,
  output fwd_sel_t   o_fwd_sel
);

  // R15 reads come from the PC path, never from a forwarded result
  always_comb begin
    o_fwd_sel = FWD_RF;
    if (i_reg_write_m && (i_ra_e == i_wa3_m) && (i_wa3_m != PC_REG)) begin
      o_fwd_sel = FWD_M;
    end else if (i_reg_write_w && (i_ra_e == i_wa3_w) && (i_wa3_w != PC_REG)) begin
      o_fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: forwarding, load-use and
// PC-write handling, data-memory wait FSM with timeout, post-reset flushing.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RST_FLUSH_CYC = 2,
  parameter int unsigned MEM_TIMEOUT   = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] RA1E,
  input  logic [3:0] RA2E,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MemReqM,
  input  logic       mem_ack,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic       MemErr
);

  localparam int unsigned    WCNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
  localparam logic [2:0]     RST_LAST = 3'(RST_FLUSH_CYC - 1);

  hz_state_t         r_state;
  logic [2:0]        r_rst_cnt;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_mem_err;

  fwd_sel_t          w_fwd_a;
  fwd_sel_t          w_fwd_b;
  logic [WCNT_W-1:0] w_wait_inc;
  logic              w_mem_miss;
  logic              w_mem_hold;
  logic              w_ldr_stall;
  logic              w_pc_wr_pend;

  hz_forward_unit u_fwd_a (
    .i_ra_e        (RA1E),
    .i_wa3_m       (WA3M),
    .i_wa3_w       (WA3W),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_fwd_sel     (w_fwd_a)
  );

  hz_forward_unit u_fwd_b (
    .i_ra_e        (RA2E),
    .i_wa3_m       (WA3M),
    .i_wa3_w       (WA3W),
    .i_reg_write_m (RegWriteM),
    .i_reg_write_w (RegWriteW),
    .o_fwd_sel     (w_fwd_b)
  );

  assign ForwardAE    = w_fwd_a;
  assign ForwardBE    = w_fwd_b;
  assign MemErr       = r_mem_err;

  assign w_ldr_stall  = MemtoRegE & RegWriteE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign w_pc_wr_pend = PCSrcD | PCSrcE | PCSrcM;
  assign w_mem_miss   = (r_state == RUN) & MemReqM & ~mem_ack;
  assign w_mem_hold   = w_mem_miss | ((r_state == MWAIT) & ~mem_ack);
  assign w_wait_inc   = (r_wait_cnt == WCNT_MAX) ? r_wait_cnt : r_wait_cnt + WCNT_ONE;

  // Sequencing FSM; the first unacknowledged cycle in RUN already counts as a wait cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= INIT;
      r_rst_cnt  <= 3'd0;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        INIT: begin
          if (r_rst_cnt == RST_LAST) r_state <= RUN;
          else                       r_rst_cnt <= r_rst_cnt + 3'd1;
        end
        RUN: begin
          if (w_mem_miss) begin
            r_wait_cnt <= WCNT_ONE;
            if (WCNT_ONE == WCNT_MAX) begin
              r_state   <= ERR;
              r_mem_err <= 1'b1;
            end else begin
              r_state   <= MWAIT;
            end
          end
        end
        MWAIT: begin
          if (mem_ack) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= w_wait_inc;
            if (w_wait_inc == WCNT_MAX) begin
              r_state   <= ERR;
              r_mem_err <= 1'b1;
            end
          end
        end
        ERR:     r_mem_err <= 1'b1;
        default: r_state   <= INIT;
      endcase
    end
  end

  // Stall/flush decode; a pending memory access overrides hazard and branch terms
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    case (r_state)
      INIT: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      ERR: begin
        {StallF, StallD, StallE, StallM} = 4'b1111;
        FlushW = 1'b1;
      end
      default: begin
        if (w_mem_hold) begin
          {StallF, StallD, StallE, StallM} = 4'b1111;
          FlushW = 1'b1;
        end else begin
          StallF = w_ldr_stall | w_pc_wr_pend;
          StallD = w_ldr_stall;
          FlushD = w_pc_wr_pend | PCSrcW | BranchTakenE;
          FlushE = w_ldr_stall | BranchTakenE;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int RST_FLUSH_CYC = 2;
  localparam int MEM_TIMEOUT   = 15;
  localparam logic [6:0] CTL_INIT = 7'b0000_110;
  localparam logic [6:0] CTL_HOLD = 7'b1111_001;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, mem_ack;
  logic [1:0] ForwardAE, ForwardBE;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [6:0] ctl;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 = post-reset flush, 1 = running, 2 = waiting on memory, 3 = error
  int m_mode      = 0;
  int m_init_left = RST_FLUSH_CYC;
  int m_waited    = 0;
  bit m_err       = 1'b0;

  assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RST_FLUSH_CYC(RST_FLUSH_CYC), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .BranchTakenE(BranchTakenE), .MemReqM(MemReqM), .mem_ack(mem_ack),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemErr(MemErr)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode <= 0; m_init_left <= RST_FLUSH_CYC; m_waited <= 0; m_err <= 1'b0;
    end else begin
      case (m_mode)
        0: if (m_init_left <= 1) m_mode <= 1; else m_init_left <= m_init_left - 1;
        1: if (MemReqM && !mem_ack) begin
             m_waited <= 1;
             if (MEM_TIMEOUT <= 1) begin m_mode <= 3; m_err <= 1'b1; end
             else m_mode <= 2;
           end
        2: if (mem_ack) begin
             m_mode <= 1; m_waited <= 0;
           end else begin
             m_waited <= m_waited + 1;
             if (m_waited + 1 >= MEM_TIMEOUT) begin m_mode <= 3; m_err <= 1'b1; end
           end
        default: m_err <= 1'b1;
      endcase
    end
  end

  function automatic logic [1:0] fwd_exp(input logic [3:0] ra);
    if (RegWriteM && ra == WA3M && WA3M != 4'd15) return 2'b10;
    if (RegWriteW && ra == WA3W && WA3W != 4'd15) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [3:0] rnd_reg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE} = '0;
    {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MemReqM, mem_ack} = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ctl !== CTL_INIT || MemErr !== 1'b0 || {ForwardAE, ForwardBE} !== 4'b0) begin
      errors++;
      $display("FAIL reset_hold: ctl=%b memerr=%b fwd=%b%b, want ctl=%b memerr=0 fwd=0000",
               ctl, MemErr, ForwardAE, ForwardBE, CTL_INIT);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (ctl !== ((k < RST_FLUSH_CYC) ? CTL_INIT : 7'b0) || MemErr !== 1'b0) begin
        errors++;
        $display("FAIL reset_flush cyc%0d: ctl=%b memerr=%b, want ctl=%b memerr=0",
                 k, ctl, MemErr, (k < RST_FLUSH_CYC) ? CTL_INIT : 7'b0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    RegWriteM = 1; WA3M = 3; RegWriteW = 1; WA3W = 3; RA1E = 3; RA2E = 7;
    #1;
    checks++;
    if (ForwardAE !== 2'b10 || ForwardBE !== 2'b00) begin
      errors++;
      $display("FAIL fwd_m_priority: A=%b B=%b, want A=10 B=00", ForwardAE, ForwardBE);
    end
    WA3M = 15; RA2E = 3;
    #1;
    checks++;
    if (ForwardAE !== 2'b01 || ForwardBE !== 2'b01) begin
      errors++;
      $display("FAIL fwd_pc_skip: A=%b B=%b, want A=01 B=01", ForwardAE, ForwardBE);
    end
    WA3M = 7; RA2E = 7; RegWriteW = 0;
    #1;
    checks++;
    if (ForwardAE !== 2'b00 || ForwardBE !== 2'b10) begin
      errors++;
      $display("FAIL fwd_b_m: A=%b B=%b, want A=00 B=10", ForwardAE, ForwardBE);
    end
    @(negedge clk);
  endtask

  task automatic test_load_use();
    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 5; RA2D = 5; RA1D = 2;
    #1;
    checks++;
    if (ctl !== 7'b1100_010) begin
      errors++;
      $display("FAIL load_use_rb: ctl=%b, want 1100010", ctl);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL load_use_release: ctl=%b, want 0000000", ctl);
    end
    MemtoRegE = 1; RegWriteE = 1; WA3E = 9; RA1D = 9; RA2D = 1; PCSrcW = 1;
    #1;
    checks++;
    if (ctl !== 7'b1100_110) begin
      errors++;
      $display("FAIL load_use_ra_pcw: ctl=%b, want 1100110", ctl);
    end
    MemtoRegE = 0; PCSrcW = 0;
    #1;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL no_load_no_stall: ctl=%b, want 0000000", ctl);
    end
    @(negedge clk);
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    MemReqM = 1; mem_ack = 1;
    #1;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL zero_cycle_mem: ctl=%b, want 0000000", ctl);
    end
    @(negedge clk);
    mem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_HOLD) begin
        errors++;
        $display("FAIL mem_wait cyc%0d: ctl=%b, want %b", i, ctl, CTL_HOLD);
      end
      @(negedge clk);
    end
    mem_ack = 1;
    #1;
    checks++;
    if (ctl !== 7'b0) begin
      errors++;
      $display("FAIL mem_ack_release: ctl=%b, want 0000000", ctl);
    end
    @(negedge clk);
    MemReqM = 0;
    repeat (2) begin
      #1;
      checks++;
      if (ctl !== 7'b0) begin
        errors++;
        $display("FAIL stray_ack: ctl=%b, want 0000000", ctl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_branch_in_wait();
    clear_inputs();
    MemReqM = 1; BranchTakenE = 1; MemtoRegE = 1; RegWriteE = 1; WA3E = 4; RA1D = 4;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_HOLD) begin
        errors++;
        $display("FAIL branch_in_wait cyc%0d: ctl=%b, want %b", i, ctl, CTL_HOLD);
      end
      @(negedge clk);
    end
    mem_ack = 1; MemtoRegE = 0;
    #1;
    checks++;
    if (ctl !== 7'b0000_110) begin
      errors++;
      $display("FAIL branch_after_ack: ctl=%b, want 0000110", ctl);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_timeout();
    clear_inputs();
    MemReqM = 1;
    for (int i = 0; i < MEM_TIMEOUT; i++) begin
      #1;
      checks++;
      if (ctl !== CTL_HOLD || MemErr !== 1'b0) begin
        errors++;
        $display("FAIL timeout_wait cyc%0d: ctl=%b memerr=%b, want %b memerr=0",
                 i, ctl, MemErr, CTL_HOLD);
      end
      @(negedge clk);
    end
    MemReqM = 0; mem_ack = 1; BranchTakenE = 1;
    repeat (3) begin
      #1;
      checks++;
      if (ctl !== CTL_HOLD || MemErr !== 1'b1) begin
        errors++;
        $display("FAIL err_sticky: ctl=%b memerr=%b, want %b memerr=1", ctl, MemErr, CTL_HOLD);
      end
      @(negedge clk);
    end
    clear_inputs();
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_INIT || MemErr !== 1'b0) begin
      errors++;
      $display("FAIL err_reset: ctl=%b memerr=%b, want %b memerr=0", ctl, MemErr, CTL_INIT);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (RST_FLUSH_CYC) @(negedge clk);
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    MemReqM = 1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_INIT) begin
      errors++;
      $display("FAIL reset_mid_wait: ctl=%b, want %b", ctl, CTL_INIT);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k <= RST_FLUSH_CYC; k++) begin
      #1;
      checks++;
      if (ctl !== ((k < RST_FLUSH_CYC) ? CTL_INIT : CTL_HOLD)) begin
        errors++;
        $display("FAIL init_ignores_mem cyc%0d: ctl=%b, want %b",
                 k, ctl, (k < RST_FLUSH_CYC) ? CTL_INIT : CTL_HOLD);
      end
      @(negedge clk);
    end
    mem_ack = 1;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_random();
    logic [6:0] exp_ctl;
    logic       ldr, pcw;
    int         ack_pct;
    for (int chunk = 0; chunk < 4; chunk++) begin
      clear_inputs();
      apply_reset();
      ack_pct = (chunk == 3) ? 3 : 60;
      for (int c = 0; c < 150; c++) begin
        RA1D = rnd_reg(); RA2D = rnd_reg(); RA1E = rnd_reg(); RA2E = rnd_reg();
        WA3E = rnd_reg(); WA3M = rnd_reg(); WA3W = rnd_reg();
        RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
        RegWriteW = 1'($urandom_range(0, 1)); MemtoRegE = 1'($urandom_range(0, 1));
        PCSrcD = ($urandom_range(0, 9) == 0); PCSrcE = ($urandom_range(0, 9) == 0);
        PCSrcM = ($urandom_range(0, 9) == 0); PCSrcW = ($urandom_range(0, 9) == 0);
        BranchTakenE = ($urandom_range(0, 7) == 0);
        MemReqM = ($urandom_range(0, 3) == 0) || (chunk == 3);
        mem_ack = ($urandom_range(0, 99) < ack_pct);
        #1;
        ldr = MemtoRegE && RegWriteE && (RA1D == WA3E || RA2D == WA3E);
        pcw = PCSrcD || PCSrcE || PCSrcM;
        if (m_mode == 0) exp_ctl = CTL_INIT;
        else if (m_mode == 3) exp_ctl = CTL_HOLD;
        else if (!mem_ack && (m_mode == 2 || MemReqM)) exp_ctl = CTL_HOLD;
        else exp_ctl = {ldr | pcw, ldr, 2'b00, pcw | PCSrcW | BranchTakenE, ldr | BranchTakenE, 1'b0};
        checks++;
        if (ctl !== exp_ctl) begin
          errors++;
          $display("FAIL rand_ctl chunk%0d cyc%0d: ctl=%b, want %b", chunk, c, ctl, exp_ctl);
        end
        checks++;
        if (ForwardAE !== fwd_exp(RA1E)) begin
          errors++;
          $display("FAIL rand_fwdA chunk%0d cyc%0d: got %b, want %b", chunk, c, ForwardAE, fwd_exp(RA1E));
        end
        checks++;
        if (ForwardBE !== fwd_exp(RA2E)) begin
          errors++;
          $display("FAIL rand_fwdB chunk%0d cyc%0d: got %b, want %b", chunk, c, ForwardBE, fwd_exp(RA2E));
        end
        checks++;
        if (MemErr !== m_err) begin
          errors++;
          $display("FAIL rand_memerr chunk%0d cyc%0d: got %b, want %b", chunk, c, MemErr, m_err);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_branch_in_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
